i_fetch_prefetch: RTL and testbench

- Instruction-fetch front end that drives the instruction memory interface read port.
- Tracks the fetch PC and issues one word read per cycle while buffer space allows.
- Captures the 1-cycle-latency read data, together with its PC, into a small FIFO.
- Presents instructions to decode over a valid/ready handshake; branch/jump redirects flush all buffered and in-flight fetches.

---
 rtl/i_fetch_prefetch_if.sv | 33 +++
 rtl/i_fetch_prefetch.sv | 127 ++++++++++++
 tb/tb_i_fetch_prefetch.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/i_fetch_prefetch_if.sv
// Fetch-unit bus bundle: control inputs, instruction memory read port and decode handshake.
interface i_fetch_prefetch_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 20,
    parameter int unsigned DEPTH        = 4
);
    localparam int unsigned COUNT_BITS = $clog2(DEPTH) + 1;

    logic                    start;
    logic                    redirect;
    logic [ADDRESS_BITS-1:0] redirect_pc;
    logic                    mem_read;
    logic [ADDRESS_BITS-1:0] mem_read_address;
    logic [DATA_WIDTH-1:0]   mem_read_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [ADDRESS_BITS-1:0] out_pc;
    logic [DATA_WIDTH-1:0]   out_instruction;
    logic [COUNT_BITS-1:0]   fifo_count;
    logic                    report;

    // Fetch unit side
    modport master (
        input  start, redirect, redirect_pc, mem_read_data, out_ready, report,
        output mem_read, mem_read_address, out_valid, out_pc, out_instruction, fifo_count
    );

    // Environment side (control, memory and decode)
    modport slave (
        output start, redirect, redirect_pc, mem_read_data, out_ready, report,
        input  mem_read, mem_read_address, out_valid, out_pc, out_instruction, fifo_count
    );
endinterface

// File: rtl/i_fetch_prefetch.sv
// Instruction-fetch front end: issues one word read per cycle while buffer space
// allows, captures 1-cycle-latency read data with its PC into a FIFO, and hands
// entries to decode over valid/ready. A redirect flushes buffered and in-flight fetches.
module i_fetch_prefetch #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 20,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned RESET_PC     = 0,
    parameter int unsigned CORE         = 0
) (
    input logic              clock,
    input logic              reset,
    i_fetch_prefetch_if.master bus
);
    localparam int unsigned PTR_BITS   = $clog2(DEPTH);
    localparam int unsigned COUNT_BITS = PTR_BITS + 1;
    localparam int unsigned OCC_BITS   = COUNT_BITS + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    logic [ADDRESS_BITS-1:0] fetch_pc;
    logic [ADDRESS_BITS-1:0] inflight_pc;
    logic                    inflight;
    logic [PTR_BITS-1:0]     rd_ptr;
    logic [PTR_BITS-1:0]     wr_ptr;
    logic [COUNT_BITS-1:0]   count;
    logic [ADDRESS_BITS-1:0] pc_mem  [DEPTH];
    logic [DATA_WIDTH-1:0]   ins_mem [DEPTH];

    logic                    has_head;
    logic                    pop;
    logic                    push;
    logic                    issue;
    logic [OCC_BITS-1:0]     occupancy;

    // Handshake and issue decisions; occupancy counts the in-flight word so the FIFO can never overflow
    always_comb begin
        has_head  = (count != '0);
        pop       = has_head & bus.out_ready;
        push      = inflight & ~bus.redirect;
        occupancy = OCC_BITS'(count) + OCC_BITS'(inflight) - OCC_BITS'(pop);
        issue     = (state == RUN) & ~bus.redirect & (occupancy < OCC_BITS'(DEPTH));
    end

    assign bus.mem_read         = issue;
    assign bus.mem_read_address = issue ? (fetch_pc >> 2) : '0;
    assign bus.out_valid        = has_head;
    assign bus.out_pc           = has_head ? pc_mem[rd_ptr]  : '0;
    assign bus.out_instruction  = has_head ? ins_mem[rd_ptr] : '0;
    assign bus.fifo_count       = count;

    // Fetch state, fetch PC and the single outstanding read
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            fetch_pc    <= ADDRESS_BITS'(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (bus.redirect) begin
            state    <= RUN;
            fetch_pc <= bus.redirect_pc;
            inflight <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                state <= RUN;
            end
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + ADDRESS_BITS'(4);
                inflight_pc <= fetch_pc;
            end
        end
    end

    // FIFO pointers and occupancy; redirect clears everything, including a concurrent pop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            count <= count + COUNT_BITS'(push) - COUNT_BITS'(pop);
        end
    end

    // FIFO storage; contents are only observed while count says they are valid
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_ptr]  <= inflight_pc;
            ins_mem[wr_ptr] <= bus.mem_read_data;
        end
    end

`ifndef SYNTHESIS
    logic [31:0] cycle_count;

    // Free-running cycle counter for the state report
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    // State report on request
    always_ff @(posedge clock) begin
        if (bus.report) begin
            $display("core %0d cycle %0d state %s fetch_pc %h mem_read %b fifo_count %0d out_valid %b out_pc %h out_instruction %h",
                     CORE, cycle_count, (state == RUN) ? "RUN" : "IDLE", fetch_pc, bus.mem_read,
                     count, has_head, bus.out_pc, bus.out_instruction);
        end
    end
`endif

endmodule

// File: tb/tb_i_fetch_prefetch.sv
// Bench for i_fetch_prefetch: a queue-based model checks the 20-bit instance every
// cycle; directed literal checks pin key latencies, and an 8-bit instance covers PC wrap.
module tb_i_fetch_prefetch;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MASK_A = 32'h000F_FFFF;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    i_fetch_prefetch_if #(.DATA_WIDTH(32), .ADDRESS_BITS(20), .DEPTH(DEPTH)) bus_a ();
    i_fetch_prefetch_if #(.DATA_WIDTH(32), .ADDRESS_BITS(8),  .DEPTH(DEPTH)) bus_b ();

    i_fetch_prefetch #(.DATA_WIDTH(32), .ADDRESS_BITS(20), .DEPTH(DEPTH), .RESET_PC(0), .CORE(0))
        dut_a (.clock(clock), .reset(reset), .bus(bus_a));
    i_fetch_prefetch #(.DATA_WIDTH(32), .ADDRESS_BITS(8), .DEPTH(DEPTH), .RESET_PC(0), .CORE(1))
        dut_b (.clock(clock), .reset(reset), .bus(bus_b));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory: word k holds 0x1000 + k, returned one cycle after the read
    always @(posedge clock) begin
        bus_a.mem_read_data <= bus_a.mem_read ? 32'h1000 + 32'(bus_a.mem_read_address) : 32'hDEAD_BEEF;
        bus_b.mem_read_data <= bus_b.mem_read ? 32'h1000 + 32'(bus_b.mem_read_address) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Behavioural model of instance A: a queue of {pc, instruction}
    typedef struct {
        int unsigned pc;
        int unsigned ins;
    } ent_t;

    ent_t        mq[$];
    bit          m_run;
    bit          m_infl;
    int unsigned m_fpc;
    int unsigned m_ipc;

    initial begin : compare
        bit          e_valid;
        bit          e_pop;
        bit          e_issue;
        int unsigned e_pc;
        int unsigned e_ins;
        forever begin
            @(negedge clock);
            if (!reset) begin
                mq.delete();
                m_run  = 1'b0;
                m_infl = 1'b0;
                m_fpc  = 0;
                m_ipc  = 0;
            end
            e_valid = (mq.size() > 0);
            e_pc    = e_valid ? mq[0].pc  : 0;
            e_ins   = e_valid ? mq[0].ins : 0;
            e_pop   = e_valid && (bus_a.out_ready === 1'b1);
            e_issue = m_run && (bus_a.redirect !== 1'b1)
                      && (int'(mq.size()) + int'(m_infl) - int'(e_pop) < int'(DEPTH));
            chk("m_mem_read",   64'(bus_a.mem_read),         64'(e_issue));
            chk("m_mem_addr",   64'(bus_a.mem_read_address), 64'(e_issue ? (m_fpc >> 2) : 0));
            chk("m_out_valid",  64'(bus_a.out_valid),        64'(e_valid));
            chk("m_out_pc",     64'(bus_a.out_pc),           64'(e_pc));
            chk("m_out_ins",    64'(bus_a.out_instruction),  64'(e_ins));
            chk("m_fifo_count", 64'(bus_a.fifo_count),       64'(mq.size()));
            chk("m_count_bound", 64'(bus_a.fifo_count <= 3'(DEPTH)), 64'(1));
            if (reset) begin
                if (bus_a.redirect) begin
                    mq.delete();
                    m_infl = 1'b0;
                    m_fpc  = 32'(bus_a.redirect_pc);
                    m_run  = 1'b1;
                end else begin
                    if (e_pop) void'(mq.pop_front());
                    if (m_infl) mq.push_back('{pc: m_ipc, ins: 32'h1000 + (m_ipc >> 2)});
                    if (e_issue) begin
                        m_ipc  = m_fpc;
                        m_infl = 1'b1;
                        m_fpc  = (m_fpc + 4) & MASK_A;
                    end else begin
                        m_infl = 1'b0;
                    end
                    if (bus_a.start) m_run = 1'b1;
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b0;
        bus_a.start = 1'b0; bus_a.redirect = 1'b0; bus_a.redirect_pc = '0;
        bus_a.out_ready = 1'b0; bus_a.report = 1'b0;
        bus_b.start = 1'b0; bus_b.redirect = 1'b0; bus_b.redirect_pc = '0;
        bus_b.out_ready = 1'b0; bus_b.report = 1'b0;
        repeat (3) tick();
        chk("reset_count", 64'(bus_a.fifo_count), 64'(0));
        chk("reset_valid", 64'(bus_a.out_valid),  64'(0));
        reset = 1'b1;
        tick();

        // Streaming with decode always ready
        bus_a.out_ready = 1'b1; bus_a.start = 1'b1;
        #1 chk("idle_no_read", 64'(bus_a.mem_read), 64'(0));
        tick(); bus_a.start = 1'b0;
        #1 chk("first_read", 64'(bus_a.mem_read), 64'(1));
        chk("first_addr", 64'(bus_a.mem_read_address), 64'(0));
        tick();
        #1 chk("second_addr", 64'(bus_a.mem_read_address), 64'(1));
        chk("not_valid_yet", 64'(bus_a.out_valid), 64'(0));
        tick();
        #1 chk("first_valid", 64'(bus_a.out_valid), 64'(1));
        chk("first_pc", 64'(bus_a.out_pc), 64'(0));
        chk("first_ins", 64'(bus_a.out_instruction), 64'h1000);
        tick();
        #1 chk("second_pc", 64'(bus_a.out_pc), 64'(4));
        chk("second_ins", 64'(bus_a.out_instruction), 64'h1001);
        bus_a.report = 1'b1;
        tick(); bus_a.report = 1'b0;
        repeat (5) tick();

        // Redirect mid-stream with a read in flight
        bus_a.redirect = 1'b1; bus_a.redirect_pc = 20'h200;
        #1 chk("redir_no_read", 64'(bus_a.mem_read), 64'(0));
        tick(); bus_a.redirect = 1'b0;
        #1 chk("redir_flushed", 64'(bus_a.fifo_count), 64'(0));
        chk("redir_addr", 64'(bus_a.mem_read_address), 64'h80);
        tick();
        #1 chk("redir_gap", 64'(bus_a.out_valid), 64'(0));
        tick();
        #1 chk("redir_valid", 64'(bus_a.out_valid), 64'(1));
        chk("redir_pc", 64'(bus_a.out_pc), 64'h200);
        chk("redir_ins", 64'(bus_a.out_instruction), 64'h1080);
        repeat (4) tick();

        // Back-pressure from reset
        reset = 1'b0;
        tick(); reset = 1'b1; bus_a.out_ready = 1'b0;
        tick(); bus_a.start = 1'b1;
        tick(); bus_a.start = 1'b0;
        repeat (6) tick();
        #1 chk("bp_full", 64'(bus_a.fifo_count), 64'(4));
        chk("bp_no_read", 64'(bus_a.mem_read), 64'(0));
        chk("bp_hold_pc", 64'(bus_a.out_pc), 64'(0));
        tick(); bus_a.out_ready = 1'b1;
        #1 chk("bp_resume_addr", 64'(bus_a.mem_read_address), 64'(4));
        chk("bp_drain0", 64'(bus_a.out_pc), 64'(0));
        tick();
        #1 chk("bp_drain1", 64'(bus_a.out_pc), 64'(4));
        tick(); tick();
        #1 chk("bp_drain3", 64'(bus_a.out_pc), 64'(12));
        tick();
        #1 chk("bp_next16", 64'(bus_a.out_pc), 64'(16));

        // Refill, then redirect in the same cycle as a pop
        bus_a.out_ready = 1'b0;
        repeat (6) tick();
        #1 chk("refull", 64'(bus_a.fifo_count), 64'(4));
        tick(); bus_a.out_ready = 1'b1; bus_a.redirect = 1'b1; bus_a.redirect_pc = 20'h400;
        #1 chk("popredir_head", 64'(bus_a.out_valid), 64'(1));
        tick(); bus_a.redirect = 1'b0;
        #1 chk("popredir_flush", 64'(bus_a.fifo_count), 64'(0));
        repeat (5) tick();

        // Reset mid-operation with three entries buffered
        bus_a.out_ready = 1'b0;
        reset = 1'b0;
        tick(); reset = 1'b1;
        tick(); bus_a.start = 1'b1;
        tick(); bus_a.start = 1'b0;
        repeat (4) tick();
        #1 chk("pre_reset_count", 64'(bus_a.fifo_count), 64'(3));
        #1 reset = 1'b0;
        #1 chk("async_count", 64'(bus_a.fifo_count), 64'(0));
        chk("async_valid", 64'(bus_a.out_valid), 64'(0));
        chk("async_pc",    64'(bus_a.out_pc), 64'(0));
        chk("async_ins",   64'(bus_a.out_instruction), 64'(0));
        chk("async_read",  64'(bus_a.mem_read), 64'(0));
        chk("async_addr",  64'(bus_a.mem_read_address), 64'(0));
        tick(); tick(); reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1 chk("idle_after_reset", 64'(bus_a.mem_read), 64'(0));
        end

        // PC wrap on both widths, redirect straight out of IDLE
        bus_a.out_ready = 1'b1; bus_a.redirect = 1'b1; bus_a.redirect_pc = 20'hFFFFC;
        bus_b.out_ready = 1'b1; bus_b.redirect = 1'b1; bus_b.redirect_pc = 8'hFC;
        #1 chk("wrap_no_read", 64'(bus_b.mem_read), 64'(0));
        tick(); bus_a.redirect = 1'b0; bus_b.redirect = 1'b0;
        #1 chk("wrap_addr0", 64'(bus_b.mem_read_address), 64'h3F);
        tick();
        #1 chk("wrap_addr1", 64'(bus_b.mem_read_address), 64'h00);
        chk("wrap_gap", 64'(bus_b.out_valid), 64'(0));
        tick();
        #1 chk("wrap_pc0", 64'(bus_b.out_pc), 64'hFC);
        chk("wrap_ins0", 64'(bus_b.out_instruction), 64'h103F);
        chk("wrap_a_pc0", 64'(bus_a.out_pc), 64'hFFFFC);
        tick();
        #1 chk("wrap_pc1", 64'(bus_b.out_pc), 64'h00);
        chk("wrap_ins1", 64'(bus_b.out_instruction), 64'h1000);
        chk("wrap_a_pc1", 64'(bus_a.out_pc), 64'h0);
        tick();
        #1 chk("wrap_pc2", 64'(bus_b.out_pc), 64'h04);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
